// File: rtl/dmem_sized_port.sv
// dmem_sized_port
//   Byte-addressed, word-organised data RAM behind a valid/ready request/response
//   port. Supports byte/half/word loads (sign- or zero-extended) and stores
//   (lane-merged). A configurable number of wait states sits between accept and
//   response. Misaligned and illegal-size accesses complete normally but report
//   rsp_err with no RAM write.
//
// Ports
//   clock, reset               rising-edge clock, async active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_we, req_size,          store flag, size (00 b, 01 h, 10 w, 11 illegal),
//   req_unsigned               zero-extend for sub-word loads
//   req_addr, req_wdata        byte address, right-justified store data
//   rsp_valid / rsp_ready      response handshake, response held until accepted
//   rsp_rdata, rsp_err         extended load data (0 for stores/errors), error flag
module dmem_sized_port #(
    parameter int    DEPTH       = 1024,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH];

    // Upper address bits alias (address wraps modulo 4*DEPTH).
    logic            unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr[31:AW+2]};

    // RAM image: zero-filled.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    end

    // With zero wait states the access commits on the accept edge itself, so the
    // commit datapath reads the live request in IDLE and the latched copy otherwise.
    logic            c_we, c_uns, c_err;
    logic [1:0]      c_size;
    logic [AW+1:0]   c_addr;
    logic [31:0]     c_wdata;
    logic [AW-1:0]   c_idx;
    logic [31:0]     rd_word, shifted, load_val, wr_word, wd_rep;
    logic [3:0]      be;

    always_comb begin
        c_we    = we_q;
        c_size  = size_q;
        c_uns   = uns_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            c_we    = req_we;
            c_size  = req_size;
            c_uns   = req_unsigned;
            c_addr  = req_addr[AW+1:0];
            c_wdata = req_wdata;
        end
        c_idx = c_addr[AW+1:2];
        c_err = (c_size == 2'b11) ||
                (c_size == 2'b01 && c_addr[0]) ||
                (c_size == 2'b10 && c_addr[1:0] != 2'b00);
    end

    // Load extraction: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        rd_word = mem[c_idx];
        shifted = rd_word >> {c_addr[1:0], 3'b000};
        case (c_size)
            2'b00:   load_val = c_uns ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = c_uns ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // Store merge: replicate data across lanes, then take only the enabled bytes.
    always_comb begin
        case (c_size)
            2'b00: begin
                be     = 4'b0001 << c_addr[1:0];
                wd_rep = {4{c_wdata[7:0]}};
            end
            2'b01: begin
                be     = c_addr[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{c_wdata[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wd_rep = c_wdata;
            end
        endcase
        wr_word = rd_word;
        for (int b = 0; b < 4; b++)
            if (be[b]) wr_word[8*b +: 8] = wd_rep[8*b +: 8];
    end

    logic commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                we_d    = req_we;
                size_d  = req_size;
                uns_d   = req_unsigned;
                addr_d  = req_addr[AW+1:0];
                wdata_d = req_wdata;
                cnt_d   = 4'd0;
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (cnt_q == 4'(LAST)) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: if (rsp_ready) begin
                state_d = S_IDLE;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        // The edge entering RESP is the single point where RAM is read or written.
        commit = (state_q != S_RESP) && (state_d == S_RESP);
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_we || c_err) ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset; a reset before commit simply never reaches this write.
    always_ff @(posedge clock) begin
        if (!reset && commit && c_we && !c_err) mem[c_idx] <= wr_word;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_sized_port.sv
module tb_dmem_sized_port;
    localparam int WS = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_sized_port #(.DEPTH(1024), .WAIT_STATES(WS), .INIT_FILE("")) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // One complete access; inputs are scrambled right after acceptance.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        rd = 32'hxxxxxxxx;
        er = 1'bx;
        while (!req_ready && n < 50) begin @(negedge clock); n++; end
        if (!req_ready) begin chk("req_ready timeout", 32'(req_ready), 32'd1); return; end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
        req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clock); n++; end
        if (!rsp_valid) begin chk("rsp_valid timeout", 32'(rsp_valid), 32'd1); return; end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
        string       nm;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp, input logic err, input string nm);
        vec_t v;
        v.we = we; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd;
        v.exp = exp; v.err = err; v.nm = nm;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        vq.push_back(mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, "st_w_10"));
        vq.push_back(mk(1, 2'b00, 0, 32'h11,   32'hFFFFFF5A, 32'h0,        0, "st_b_11"));
        vq.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,        32'hDEAD5AEF, 0, "ld_w_10"));
        vq.push_back(mk(0, 2'b00, 0, 32'h13,   32'h0,        32'hFFFFFFDE, 0, "ld_bs_13"));
        vq.push_back(mk(0, 2'b00, 1, 32'h13,   32'h0,        32'h000000DE, 0, "ld_bu_13"));
        vq.push_back(mk(0, 2'b00, 0, 32'h12,   32'h0,        32'hFFFFFFAD, 0, "ld_bs_12"));
        vq.push_back(mk(0, 2'b01, 1, 32'h10,   32'h0,        32'h00005AEF, 0, "ld_hu_10"));
        vq.push_back(mk(0, 2'b01, 0, 32'h12,   32'h0,        32'hFFFFDEAD, 0, "ld_hs_12"));
        vq.push_back(mk(1, 2'b01, 0, 32'h22,   32'hABCD8001, 32'h0,        0, "st_h_22"));
        vq.push_back(mk(0, 2'b01, 0, 32'h22,   32'h0,        32'hFFFF8001, 0, "ld_hs_22"));
        vq.push_back(mk(0, 2'b01, 1, 32'h22,   32'h0,        32'h00008001, 0, "ld_hu_22"));
        vq.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        32'h80010000, 0, "ld_w_20"));
        vq.push_back(mk(1, 2'b01, 0, 32'h20,   32'h00001234, 32'h0,        0, "st_h_20"));
        vq.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        32'h80011234, 0, "ld_w_20b"));
        vq.push_back(mk(1, 2'b10, 0, 32'h04,   32'hCAFEF00D, 32'h0,        0, "st_w_04"));
        vq.push_back(mk(0, 2'b10, 0, 32'h06,   32'h0,        32'h0,        1, "ld_w_06_mis"));
        vq.push_back(mk(0, 2'b01, 1, 32'h03,   32'h0,        32'h0,        1, "ld_h_03_mis"));
        vq.push_back(mk(0, 2'b11, 0, 32'h04,   32'h0,        32'h0,        1, "ld_size11"));
        vq.push_back(mk(1, 2'b10, 0, 32'h06,   32'h12345678, 32'h0,        1, "st_w_06_mis"));
        vq.push_back(mk(1, 2'b11, 0, 32'h04,   32'h0,        32'h0,        1, "st_size11"));
        vq.push_back(mk(0, 2'b10, 0, 32'h04,   32'h0,        32'hCAFEF00D, 0, "ld_w_04_kept"));
        vq.push_back(mk(1, 2'b10, 0, 32'h1000, 32'h11223344, 32'h0,        0, "st_w_1000"));
        vq.push_back(mk(0, 2'b10, 0, 32'h0,    32'h0,        32'h11223344, 0, "ld_w_0_wrap"));

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst rsp_err",   32'(rsp_err), 32'd0);
        reset = 1'b0;

        // Reset during WAIT of a store aborts it without writing RAM.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(negedge clock);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        for (int i = 0; i < WS + 1; i++) begin
            @(negedge clock);
            chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b0;
        access(0, 2'b10, 0, 32'h10, 32'h0, rd, er);
        chk("abort ld_w_10", rd, 32'h0);
        chk("abort ld err", 32'(er), 32'd0);

        foreach (vq[i]) begin
            access(vq[i].we, vq[i].sz, vq[i].uns, vq[i].a, vq[i].wd, rd, er);
            chk({vq[i].nm, " rdata"}, rd, vq[i].exp);
            chk({vq[i].nm, " err"}, 32'(er), 32'(vq[i].err));
        end

        // Latency and back-pressure; a store offered while busy must be ignored.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10;
        @(negedge clock);
        req_we = 1'b1; req_wdata = 32'h0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(negedge clock); lat++; end
        // Counting the accept edge as the first, rsp_valid appears after edge WS+1.
        chk("latency", 32'(lat), 32'(WS));
        for (int i = 0; i < 5; i++) begin
            chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall rsp_rdata", rsp_rdata, 32'hDEAD5AEF);
            chk("stall req_ready", 32'(req_ready), 32'd0);
            @(negedge clock);
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("post rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post req_ready", 32'(req_ready), 32'd1);
        access(0, 2'b10, 0, 32'h10, 32'h0, rd, er);
        chk("ignored store", rd, 32'hDEAD5AEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
